// File: rtl/conv_gen_if.sv
// rtl/conv_gen_if.sv - conv_gen start/busy handshake plus image, weight and result memory ports
interface conv_gen_if;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic [5:0]  kaddr;
  logic [19:0] kdata;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;

  modport master (
    input  ready, idata, kdata, cdata_rd,
    output busy, iaddr, kaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
  modport slave (
    output ready, idata, kdata, cdata_rd,
    input  busy, iaddr, kaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/conv_gen.sv
// rtl/conv_gen.sv - 3x3 zero-padded convolution with bias, ReLU and saturation, followed by optional 2x2 max-pool, per kernel
module conv_gen #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int NUM_K   = 2,
  parameter int POOL_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  conv_gen_if.master bus
);
  typedef enum logic [1:0] {IDLE, CONV, POOL, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cyc_q, cyc_d;
  logic [6:0]         row_q, row_d, col_q, col_d;
  logic [1:0]         k_q, k_d;
  logic               tapv_q, tapv_d, pv_q;
  logic signed [43:0] acc_q, acc_d;
  logic [19:0]        pmax_q, pmax_d, pool_wr_q, pool_wr_d;
  logic               busy_q, busy_d, crd_q, crd_d, cwr_q, cwr_d;
  logic [11:0]        iaddr_q, iaddr_d, caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
  logic [5:0]         kaddr_q, kaddr_d;
  logic [2:0]         csel_q, csel_d;
  int                 tap_r, tap_c;
  logic               in_img;
  logic signed [39:0] prod;
  logic [43:0]        sum;
  logic [19:0]        conv_res;

  assign prod = $signed(bus.idata) * $signed(bus.kdata);
  // bias arrives in the write cycle itself, so the conv result is formed combinationally from it
  assign sum  = acc_q + {{8{bus.kdata[19]}}, bus.kdata, 16'h0} + 44'd32768;

  always_comb begin
    conv_res = sum[35:16];
    if (sum[43])          conv_res = '0;
    else if (|sum[42:35]) conv_res = 20'h7FFFF;
  end

  // next-state: counters advance at the end of each output's last cycle
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (bus.ready) begin
        state_d = CONV;
        cyc_d   = '0;
        row_d   = '0;
        col_d   = '0;
        k_d     = '0;
      end
      CONV: if (cyc_q == 4'd10) begin
        cyc_d = '0;
        if (col_q == 7'(IMG_W - 1)) begin
          col_d = '0;
          if (row_q == 7'(IMG_H - 1)) begin
            row_d = '0;
            if (POOL_EN != 0)            state_d = POOL;
            else if (k_q == 2'(NUM_K - 1)) state_d = DONE;
            else                          k_d = k_q + 2'd1;
          end else row_d = row_q + 7'd1;
        end else col_d = col_q + 7'd1;
      end else cyc_d = cyc_q + 4'd1;
      POOL: if (cyc_q == 4'd5) begin
        cyc_d = '0;
        if (col_q == 7'(IMG_W / 2 - 1)) begin
          col_d = '0;
          if (row_q == 7'(IMG_H / 2 - 1)) begin
            row_d = '0;
            if (k_q == 2'(NUM_K - 1)) state_d = DONE;
            else begin
              state_d = CONV;
              k_d     = k_q + 2'd1;
            end
          end else row_d = row_q + 7'd1;
        end else col_d = col_q + 7'd1;
      end else cyc_d = cyc_q + 4'd1;
      default: state_d = IDLE;
    endcase
  end

  // registered outputs are derived from the next-state values
  always_comb begin
    busy_d     = (state_d == CONV) || (state_d == POOL);
    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    iaddr_d    = '0;
    kaddr_d    = '0;
    caddr_rd_d = '0;
    caddr_wr_d = '0;
    csel_d     = '0;
    tapv_d     = 1'b0;
    tap_r      = int'(row_d) + int'(cyc_d / 4'd3) - 1;
    tap_c      = int'(col_d) + int'(cyc_d % 4'd3) - 1;
    in_img     = (tap_r >= 0) && (tap_r < IMG_H) && (tap_c >= 0) && (tap_c < IMG_W);
    if (state_d == CONV) begin
      if (cyc_d < 4'd9) begin
        tapv_d  = in_img;
        iaddr_d = in_img ? 12'(tap_r * IMG_W + tap_c) : '0;
        kaddr_d = 6'(int'(k_d) * 10 + int'(cyc_d));
      end else if (cyc_d == 4'd9) begin
        kaddr_d = 6'(int'(k_d) * 10 + 9);
      end else begin
        cwr_d      = 1'b1;
        csel_d     = 3'(int'(k_d) + 1);
        caddr_wr_d = 12'(int'(row_d) * IMG_W + int'(col_d));
      end
    end else if (state_d == POOL) begin
      if (cyc_d < 4'd4) begin
        crd_d      = 1'b1;
        csel_d     = 3'(int'(k_d) + 1);
        caddr_rd_d = 12'((2 * int'(row_d) + int'(cyc_d[1])) * IMG_W + 2 * int'(col_d) + int'(cyc_d[0]));
      end else if (cyc_d == 4'd5) begin
        cwr_d      = 1'b1;
        csel_d     = 3'(NUM_K + 1 + int'(k_d));
        caddr_wr_d = 12'(int'(row_d) * (IMG_W / 2) + int'(col_d));
      end
    end
  end

  // pv_q marks that the data returning this cycle belongs to an in-image tap
  always_comb begin
    acc_d     = acc_q;
    pmax_d    = pmax_q;
    pool_wr_d = '0;
    if (state_q == CONV) begin
      if (cyc_q == 4'd0) acc_d = '0;
      else if (pv_q)     acc_d = acc_q + {{4{prod[39]}}, prod};
    end
    if (state_q == POOL) begin
      if (cyc_q == 4'd1) pmax_d = bus.cdata_rd;
      else if (cyc_q >= 4'd2 && cyc_q <= 4'd4 && $signed(bus.cdata_rd) > $signed(pmax_q))
        pmax_d = bus.cdata_rd;
      if (cyc_q == 4'd4) pool_wr_d = pmax_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      tapv_q     <= 1'b0;
      pv_q       <= 1'b0;
      acc_q      <= '0;
      pmax_q     <= '0;
      pool_wr_q  <= '0;
      busy_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      iaddr_q    <= '0;
      kaddr_q    <= '0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      csel_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      tapv_q     <= tapv_d;
      pv_q       <= tapv_q;
      acc_q      <= acc_d;
      pmax_q     <= pmax_d;
      pool_wr_q  <= pool_wr_d;
      busy_q     <= busy_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      iaddr_q    <= iaddr_d;
      kaddr_q    <= kaddr_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      csel_q     <= csel_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.crd      = crd_q;
  assign bus.cwr      = cwr_q;
  assign bus.iaddr    = iaddr_q;
  assign bus.kaddr    = kaddr_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.csel     = csel_q;
  assign bus.cdata_wr = (cwr_q && state_q == CONV) ? conv_res : pool_wr_q;
endmodule

// File: tb/tb_conv_gen.sv
// tb/tb_conv_gen.sv - directed-vector bench for conv_gen on a 4x4 image with two kernels and pooling
module tb_conv_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NK = 2;

  typedef struct {
    bit          ramp;
    logic [19:0] pix, we, wc, bias, ec, ee, ei, ep;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  conv_gen_if bus();
  conv_gen #(.IMG_W(W), .IMG_H(H), .NUM_K(NK), .POOL_EN(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [19:0] img  [16];
  logic [19:0] kmem [32];
  logic [19:0] cmem [8][16];
  logic [11:0] ia_s = '0, ra_s = '0;
  logic [5:0]  ka_s = '0;
  logic [2:0]  cs_s = '0;
  int nwr = 0, n_both = 0, n_csel = 0, n_kaddr = 0, n_badsel = 0;
  int n_chk = 0, n_fail = 0;

  always @(negedge clk) begin
    ia_s = bus.iaddr;
    ka_s = bus.kaddr;
    ra_s = bus.caddr_rd;
    cs_s = bus.csel;
    if (bus.cwr) begin
      cmem[bus.csel][bus.caddr_wr[3:0]] = bus.cdata_wr;
      nwr++;
      if (bus.csel == 3'd0 || bus.csel > 3'd4) n_badsel++;
    end
    if (bus.crd && bus.cwr) n_both++;
    if (!bus.crd && !bus.cwr && bus.csel != 3'd0) n_csel++;
    if (bus.kaddr != 6'd0 && (bus.crd || !bus.busy)) n_kaddr++;
  end

  always @(posedge clk) begin
    #1;
    bus.idata    = img[ia_s[3:0]];
    bus.kdata    = kmem[ka_s[4:0]];
    bus.cdata_rd = cmem[cs_s][ra_s[3:0]];
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] exp_conv(input vec_t v, input int a);
    int nb;
    if (v.ramp) return img[a];
    nb = ((a / W == 0 || a / W == H - 1) ? 1 : 0) + ((a % W == 0 || a % W == W - 1) ? 1 : 0);
    return (nb == 2) ? v.ec : ((nb == 1) ? v.ee : v.ei);
  endfunction

  function automatic logic [19:0] exp_pool(input vec_t v, input int j);
    if (v.ramp) return img[(2 * (j / 2) + 1) * W + 2 * (j % 2) + 1];
    return v.ep;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 16; i++) img[i] = v.ramp ? 20'((i + 1) * 'h7000) : v.pix;
    for (int k = 0; k < NK; k++)
      for (int t = 0; t < 10; t++) kmem[k * 10 + t] = (t == 9) ? v.bias : ((t == 4) ? v.wc : v.we);
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 16; a++) cmem[s][a] = 20'hABCDE;
  endtask

  task automatic check_mem(input vec_t v, input int id);
    for (int k = 0; k < NK; k++) begin
      for (int a = 0; a < 16; a++)
        chk($sformatf("v%0d conv k%0d a%0d", id, k, a), 64'(cmem[k + 1][a]), 64'(exp_conv(v, a)));
      for (int j = 0; j < 4; j++)
        chk($sformatf("v%0d pool k%0d a%0d", id, k, j), 64'(cmem[NK + 1 + k][j]), 64'(exp_pool(v, j)));
    end
  endtask

  task automatic run_pass(input bit hold, output int bcyc, output int first_wr, output int wr_to_idle, output bit tmo);
    int last_wr;
    last_wr  = -1;
    first_wr = -1;
    bcyc     = 0;
    tmo      = 1'b0;
    @(negedge clk);
    chk("busy before ready", 64'(bus.busy), 64'd0);
    bus.ready = 1'b1;
    @(negedge clk);
    if (!hold) bus.ready = 1'b0;
    while (bus.busy && bcyc < 2000) begin
      bcyc++;
      if (bus.cwr) begin
        last_wr = bcyc;
        if (first_wr < 0) first_wr = bcyc;
      end
      @(negedge clk);
    end
    bus.ready  = 1'b0;
    tmo        = (bcyc >= 2000);
    wr_to_idle = bcyc + 1 - last_wr;
  endtask

  task automatic run_and_check(input vec_t v, input int id, input bit hold);
    int bcyc, first_wr, wr_to_idle, w0;
    bit tmo;
    w0 = nwr;
    run_pass(hold, bcyc, first_wr, wr_to_idle, tmo);
    chk($sformatf("v%0d timeout", id), 64'(tmo), 64'd0);
    chk($sformatf("v%0d busy cycles", id), 64'(bcyc), 64'd400);
    chk($sformatf("v%0d first write cycle", id), 64'(first_wr), 64'd11);
    chk($sformatf("v%0d last write to idle", id), 64'(wr_to_idle), 64'd1);
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d write count", id), 64'(nwr - w0), 64'd40);
    check_mem(v, id);
  endtask

  initial begin
    vec_t tv [6];
    int   w0, nb;
    tv[0] = '{1'b1, 20'h0,     20'h0,     20'h10000, 20'h0,     20'h0,     20'h0,     20'h0,     20'h0};
    tv[1] = '{1'b0, 20'h10000, 20'h10000, 20'h10000, 20'h0,     20'h40000, 20'h60000, 20'h7FFFF, 20'h7FFFF};
    tv[2] = '{1'b0, 20'h10000, 20'h0,     20'h0,     20'hF8000, 20'h0,     20'h0,     20'h0,     20'h0};
    tv[3] = '{1'b0, 20'h10000, 20'h0,     20'h0,     20'h00001, 20'h00001, 20'h00001, 20'h00001, 20'h00001};
    tv[4] = '{1'b0, 20'h10000, 20'hF0000, 20'h60000, 20'h0,     20'h30000, 20'h10000, 20'h0,     20'h30000};
    tv[5] = '{1'b0, 20'h00001, 20'h08000, 20'h08000, 20'h0,     20'h00002, 20'h00003, 20'h00005, 20'h00005};

    bus.ready = 1'b0;
    bus.idata = '0;
    bus.kdata = '0;
    bus.cdata_rd = '0;
    load(tv[0]);
    repeat (3) @(negedge clk);
    chk("reset ctl", 64'({bus.busy, bus.crd, bus.cwr, bus.csel, bus.kaddr}), 64'd0);
    chk("reset addr", 64'({bus.iaddr, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr}), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load(tv[i]);
      run_and_check(tv[i], i, 1'b0);
    end

    // abort at CONV cycle 50, then verify a clean rerun
    load(tv[0]);
    @(negedge clk);
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    repeat (49) @(negedge clk);
    chk("busy before abort", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort ctl", 64'({bus.busy, bus.crd, bus.cwr, bus.csel, bus.kaddr}), 64'd0);
    chk("abort addr", 64'({bus.iaddr, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    w0 = nwr;
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy) nb++;
    end
    chk("writes after abort", 64'(nwr - w0), 64'd0);
    chk("busy after abort", 64'(nb), 64'd0);
    load(tv[0]);
    run_and_check(tv[0], 10, 1'b0);

    // ready held high for the whole pass
    load(tv[1]);
    w0 = nwr;
    run_and_check(tv[1], 11, 1'b1);
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) nb++;
    end
    chk("no second pass", 64'(nb), 64'd0);
    chk("held ready writes", 64'(nwr - w0), 64'd40);

    chk("crd and cwr together", 64'(n_both), 64'd0);
    chk("csel while idle bus", 64'(n_csel), 64'd0);
    chk("kaddr outside conv", 64'(n_kaddr), 64'd0);
    chk("bad write csel", 64'(n_badsel), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
